// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI receive path.
// Length decode and mask helpers are pure combinational functions.
// No flow control lives here.
package spi_pkg;

    localparam int MIN_LEN = 8;
    localparam int MAX_LEN = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_t;

    // Word length field: 0 encodes 32, short lengths are raised to the minimum.
    function automatic logic [5:0] len_decode(input logic [4:0] len);
        if (len == 5'd0) begin
            return 6'(MAX_LEN);
        end else if (len < 5'(MIN_LEN)) begin
            return 6'(MIN_LEN);
        end else begin
            return {1'b0, len};
        end
    endfunction

    // Right-aligned mask covering the low l bits of a word.
    function automatic logic [31:0] len_mask(input logic [5:0] l);
        if (l >= 6'(MAX_LEN)) begin
            return '1;
        end else begin
            return (32'd1 << l) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/spi_rx_holdbuf.sv
// Single-entry valid/ready holding register with sticky overrun flag.
// Latency: a word offered in cycle t is presented on out_vld/out_dat at t+1.
// Backpressure: a word arriving while full and not being drained is dropped and flags overrun.
module spi_rx_holdbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] in_dat,
    input  logic        in_crc,
    input  logic        out_rdy,
    input  logic        ovr_clr,
    output logic        out_vld,
    output logic [31:0] out_dat,
    output logic        out_crc,
    output logic        overrun
);

    logic load;
    logic drop;

    // Load when empty or when the current entry leaves this cycle; otherwise the newcomer is lost.
    always_comb begin
        load = in_vld && (!out_vld || out_rdy);
        drop = in_vld && out_vld && !out_rdy;
    end

    // Holding register and overrun flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_crc <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                out_vld <= 1'b1;
                out_dat <= in_dat;
                out_crc <= in_crc;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_rx_ctrl.sv
// SPI receive controller: LSB-first deserialiser of 8..32 bit words with CRC word check.
// Latency: bit 0 sampled at t, word and crc_err visible at t+L.
// Backpressure: single holding entry; words completing while it is full are dropped (overrun).
module spi_rx_ctrl
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        sdi,
    input  logic [4:0]  data_len,
    input  logic        crc_phase,
    input  logic [31:0] crc_calc,
    input  logic        rx_ready,
    input  logic        ovr_clr,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_is_crc,
    output logic        crc_err,
    output logic        overrun,
    output logic        rx_abort,
    output logic [4:0]  bit_count,
    output logic        rx_busy
);

    rx_state_t   state;
    logic [4:0]  cnt;
    logic [5:0]  len_q;
    logic        crc_q;
    logic [31:0] asm_q;

    logic [31:0] word_mask;
    logic [31:0] word_dat;
    logic        word_done;

    // The final bit is merged combinationally so the word can be handed over in its last-bit cycle.
    always_comb begin
        word_mask = len_mask(len_q);
        word_dat  = (asm_q | ({31'b0, sdi} << cnt)) & word_mask;
        word_done = (state == ST_RECV) && rx_en && ({1'b0, cnt} == (len_q - 6'd1));
    end

    // Receive FSM: assembles bits, tracks position, and generates abort and CRC-mismatch pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len_q    <= 6'(MIN_LEN);
            crc_q    <= 1'b0;
            asm_q    <= '0;
            crc_err  <= 1'b0;
            rx_abort <= 1'b0;
        end else begin
            rx_abort <= 1'b0;
            // The check runs even when the word is dropped by the holding register.
            crc_err  <= word_done && crc_q && (word_dat != (crc_calc & word_mask));

            case (state)
                ST_IDLE: begin
                    if (rx_en) begin
                        asm_q <= {31'b0, sdi};
                        len_q <= len_decode(data_len);
                        crc_q <= crc_phase;
                        cnt   <= 5'd1;
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (!rx_en) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        asm_q    <= '0;
                        rx_abort <= 1'b1;
                    end else if (word_done) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        asm_q[cnt] <= sdi;
                        cnt        <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bit_count = cnt;
    assign rx_busy   = (state == ST_RECV);

    spi_rx_holdbuf u_holdbuf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (word_done),
        .in_dat  (word_dat),
        .in_crc  (crc_q),
        .out_rdy (rx_ready),
        .ovr_clr (ovr_clr),
        .out_vld (rx_valid),
        .out_dat (rx_data),
        .out_crc (rx_is_crc),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_spi_rx_ctrl.sv
// Directed bench for spi_rx_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Each scenario task carries its own expected values.
module tb_spi_rx_ctrl;

    logic        clk;
    logic        rst;
    logic        rx_en;
    logic        sdi;
    logic [4:0]  data_len;
    logic        crc_phase;
    logic [31:0] crc_calc;
    logic        rx_ready;
    logic        ovr_clr;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_is_crc;
    logic        crc_err;
    logic        overrun;
    logic        rx_abort;
    logic [4:0]  bit_count;
    logic        rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    spi_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .sdi       (sdi),
        .data_len  (data_len),
        .crc_phase (crc_phase),
        .crc_calc  (crc_calc),
        .rx_ready  (rx_ready),
        .ovr_clr   (ovr_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_is_crc (rx_is_crc),
        .crc_err   (crc_err),
        .overrun   (overrun),
        .rx_abort  (rx_abort),
        .bit_count (bit_count),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive nbits bits of w LSB first with rx_en high; rx_en is left high on return.
    task automatic send_word(input logic [31:0] w, input int nbits, input logic [4:0] dlen, input logic crc);
        for (int i = 0; i < nbits; i++) begin
            rx_en     = 1'b1;
            sdi       = w[i];
            data_len  = dlen;
            crc_phase = crc;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if ({rx_data, rx_valid, rx_is_crc, crc_err, overrun, rx_abort, bit_count, rx_busy} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h vld=%b crc=%b err=%b ovr=%b abt=%b cnt=%0d busy=%b, expected all zero",
                     rx_data, rx_valid, rx_is_crc, crc_err, overrun, rx_abort, bit_count, rx_busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] bits;
        logic [4:0] exp_cnt;
        bits = 8'hA5;
        rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_en    = 1'b1;
            sdi      = bits[i];
            data_len = 5'd8;
            step();
            exp_cnt = (i == 7) ? 5'd0 : 5'(i + 1);
            n_tests++;
            if (bit_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL basic_bit_count[%0d]: got %0d expected %0d", i, bit_count, exp_cnt);
            end
            if (i < 7) begin
                n_tests++;
                if (rx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, rx_valid);
                end
            end
        end
        rx_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000_00A5 || rx_is_crc !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word: got vld=%b data=%h crc=%b expected vld=1 data=000000a5 crc=0", rx_valid, rx_data, rx_is_crc);
        end
        step();
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL basic_hold: got vld=%b data=%h expected vld=1 data=000000a5", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        step();
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got vld=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        send_word(32'hDEAD_BEEF, 32, 5'd0, 1'b0);
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'hDEAD_BEEF || rx_busy !== 1'b0 || bit_count !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_first: got vld=%b data=%h busy=%b cnt=%0d expected vld=1 data=deadbeef busy=0 cnt=0",
                     rx_valid, rx_data, rx_busy, bit_count);
        end
        send_word(32'h0000_003C, 8, 5'd3, 1'b0);
        rx_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000_003C) begin
            n_fail++;
            $display("FAIL b2b_second: got vld=%b data=%h expected vld=1 data=0000003c", rx_valid, rx_data);
        end
        step();
    endtask

    task automatic test_crc();
        rx_ready = 1'b1;
        crc_calc = 32'hFFFF_1234;
        send_word(32'h0000_1234, 16, 5'd16, 1'b1);
        rx_en = 1'b0;
        crc_phase = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000_1234 || rx_is_crc !== 1'b1 || crc_err !== 1'b0) begin
            n_fail++;
            $display("FAIL crc_match: got vld=%b data=%h crc=%b err=%b expected vld=1 data=00001234 crc=1 err=0",
                     rx_valid, rx_data, rx_is_crc, crc_err);
        end
        step();
        crc_calc = 32'h0000_1235;
        send_word(32'h0000_1234, 16, 5'd16, 1'b1);
        rx_en = 1'b0;
        crc_phase = 1'b0;
        n_tests++;
        if (crc_err !== 1'b1 || rx_is_crc !== 1'b1) begin
            n_fail++;
            $display("FAIL crc_mismatch: got err=%b crc=%b expected err=1 crc=1", crc_err, rx_is_crc);
        end
        step();
        n_tests++;
        if (crc_err !== 1'b0) begin
            n_fail++;
            $display("FAIL crc_err_pulse: got err=%b expected 0 one cycle later", crc_err);
        end
        crc_calc = 32'h0;
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_word(32'h11, 8, 5'd8, 1'b0);
        send_word(32'h22, 8, 5'd8, 1'b0);
        rx_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h11 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got vld=%b data=%h ovr=%b expected vld=1 data=00000011 ovr=1",
                     rx_valid, rx_data, overrun);
        end
        rx_ready = 1'b1;
        ovr_clr  = 1'b1;
        step();
        ovr_clr = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got vld=%b ovr=%b expected vld=0 ovr=0", rx_valid, overrun);
        end
    endtask

    task automatic test_abort();
        rx_ready = 1'b1;
        send_word(32'hFF, 5, 5'd8, 1'b0);
        rx_en = 1'b0;
        step();
        n_tests++;
        if (rx_abort !== 1'b1 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || bit_count !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_pulse: got abt=%b vld=%b busy=%b cnt=%0d expected abt=1 vld=0 busy=0 cnt=0",
                     rx_abort, rx_valid, rx_busy, bit_count);
        end
        step();
        n_tests++;
        if (rx_abort !== 1'b0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got abt=%b vld=%b expected abt=0 vld=0", rx_abort, rx_valid);
        end
        send_word(32'h5A, 8, 5'd8, 1'b0);
        rx_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h5A) begin
            n_fail++;
            $display("FAIL abort_next_word: got vld=%b data=%h expected vld=1 data=0000005a", rx_valid, rx_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b0;
        send_word(32'h77, 8, 5'd8, 1'b0);
        send_word(32'hFF, 3, 5'd8, 1'b0);
        n_tests++;
        if (rx_valid !== 1'b1 || bit_count !== 5'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre: got vld=%b cnt=%0d expected vld=1 cnt=3", rx_valid, bit_count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({rx_data, rx_valid, rx_is_crc, crc_err, overrun, rx_abort, bit_count, rx_busy} !== 42'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got data=%h vld=%b cnt=%0d busy=%b abt=%b expected all zero",
                     rx_data, rx_valid, bit_count, rx_busy, rx_abort);
        end
        rx_en = 1'b0;
        step();
        rst = 1'b0;
        rx_ready = 1'b1;
        step();
        send_word(32'h96, 8, 5'd8, 1'b0);
        rx_en = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h96 || rx_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_recover: got vld=%b data=%h abt=%b expected vld=1 data=00000096 abt=0",
                     rx_valid, rx_data, rx_abort);
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        rx_en     = 1'b0;
        sdi       = 1'b0;
        data_len  = 5'd8;
        crc_phase = 1'b0;
        crc_calc  = 32'h0;
        rx_ready  = 1'b0;
        ovr_clr   = 1'b0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_crc();
        test_overrun();
        test_abort();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rx_ctrl.md
# spi_rx_ctrl

- Receive-side counterpart of the SPI transmit controller.
- Deserialises one bit per `clk` from `sdi`, LSB first, into words of 8–32 bits; length is latched at word start.
- Delivers each word through a single-entry valid/ready holding register.
- A word marked as CRC is compared against a locally computed CRC, with the result flagged.

## Interface
Parameters:
- none; widths fixed by `spi_pkg` (`MIN_LEN` = 8, `MAX_LEN` = 32)

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `rx_en` in 1: frame active; `sdi` is sampled every cycle while high.
- `sdi` in 1: serial data bit.
- `data_len` in 5: word length, sampled at word start. 0 means 32; 1–7 clamp to 8; 8–31 are used as given.
- `crc_phase` in 1: the word starting this cycle is a CRC word; sampled at word start.
- `crc_calc` in 32: locally computed CRC; sampled in the last-bit cycle of a CRC word.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `ovr_clr` in 1: clears `overrun`.
- `rx_data` out 32: received word, right-aligned; bits ≥ L are zero.
- `rx_valid` out 1: `rx_data` is valid; held until accepted.
- `rx_is_crc` out 1: the word in the holding register was a CRC word.
- `crc_err` out 1: one-cycle pulse on CRC mismatch.
- `overrun` out 1: sticky; a completed word was dropped.
- `rx_abort` out 1: one-cycle pulse; a partial word was discarded.
- `bit_count` out 5: number of bits received so far in the current word.
- `rx_busy` out 1: state is RECV.

## Operation
FSM states: IDLE and RECV.

IDLE
- If `rx_en`=1, in the same cycle:
  - sample `sdi` into assembly bit 0;
  - latch L = decode(`data_len`) and `crc_phase`;
  - set cnt = 1 and go to RECV.
- If `rx_en`=0, stay in IDLE.

RECV, with `rx_en`=1
- Store `sdi` at assembly bit cnt.
- If cnt = L−1, the word completes: set cnt = 0, go to IDLE, and raise the completion event.
- Otherwise cnt increments.
- Back-to-back words need no gap: if `rx_en` stays high, the next word's bit 0 is sampled in the cycle right after the last bit, with a fresh L.

RECV, with `rx_en`=0
- Abort: go to IDLE, set cnt = 0 and clear the assembly register.
- `rx_abort` pulses on the next cycle; nothing is delivered.

Completion event
- If the holding register is empty, or is being accepted this cycle (`rx_valid` & `rx_ready`): load `rx_data` (masked to L bits) and `rx_is_crc`; `rx_valid` = 1 next cycle.
- Otherwise: drop the new word and set `overrun`.
- For a CRC word, the masked word is compared with `crc_calc & mask(L)`. On inequality, `crc_err` pulses. The comparison is made whether or not the word is dropped.

Holding register
- `rx_valid` clears on `rx_valid` & `rx_ready`, unless a new word loads in the same cycle, in which case it stays 1.

`overrun` clear
- Cleared by `ovr_clr`=1.
- If a drop and `ovr_clr` occur in the same cycle, set wins.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_is_crc`=0, `crc_err`=0, `overrun`=0, `rx_abort`=0, `bit_count`=0, `rx_busy`=0; state IDLE, cnt 0.
- Reset mid-word discards all state asynchronously; no pulses are issued.
- Latency: if bit 0 is sampled at cycle t, the last bit is sampled at t+L−1.
- `rx_valid`, `rx_data` and `crc_err` are registered outputs, so they appear at t+L.
- `bit_count` is registered: 0 in IDLE and equal to cnt in RECV, one cycle after the sample.
- `rx_valid` is never withdrawn without acceptance; `rx_data` is stable while `rx_valid`=1 and `rx_ready`=0.

## Structure
Package `spi_pkg`:
- state enum;
- constants `MIN_LEN`, `MAX_LEN`;
- `len_decode()` function (0→32, <8→8);
- `len_mask()` function returning the 32-bit mask for L.

Sub-module: one natural sub-module, `spi_rx_holdbuf`, implementing the single-entry valid/ready register with overrun detection. It is reusable by other receive blocks.

## Test plan
- len=8, `sdi` = 1,0,1,0,0,1,0,1 starting at cycle 0 → `rx_data`=0x000000A5 and `rx_valid`=1 at cycle 8; `bit_count` runs 1..7 then 0.
- len=0 (32), then len=3 (clamped to 8), back-to-back words 0xDEADBEEF and 0x3C with `rx_en` held high → two words delivered; the second word's bit 0 is sampled at cycle 32.
- `crc_phase`=1, len=16, received 0x1234 with `crc_calc`=0xFFFF1234 → `rx_is_crc`=1 and no `crc_err`. Repeat with `crc_calc`=0x1235 → `crc_err` pulses exactly once at completion+1.
- `rx_ready`=0 across two completed 8-bit words → first word retained, `overrun`=1. Then assert `rx_ready` and `ovr_clr` → `rx_valid` drops and `overrun` clears.
- `rx_en` dropped after 5 of 8 bits → `rx_abort` pulses, no `rx_valid`. The next frame receives 0x5A correctly.
- `rst` asserted mid-word while `rx_valid`=1 → all outputs 0 immediately. After release, a new 8-bit word is received normally.
